// File: rtl/alu_share_sequencer.sv
// Round-robin sharing of one combinational 8-bit ALU between two 16-bit requesters.
// Each granted operation runs as a low-byte pass then a high-byte pass with carry chained through ci.
module alu_share_sequencer #(
  parameter int NPORT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [2:0]  opt0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        req1,
  input  logic [2:0]  opt1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        res_zero,
  output logic        res_co,
  output logic        busy,
  output logic        grant_id,
  output logic [2:0]  alu_opt,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_ci,
  input  logic [7:0]  alu_s,
  input  logic        alu_zero,
  input  logic        alu_co
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state;
  logic [NPORT-1:0]   done_q;
  logic               last_grant;
  logic [2:0]         opt_l;
  logic [15:0]        a_l;
  logic [15:0]        b_l;
  logic [7:0]         sl;
  logic               ct;
  logic               z_lo;
  logic               pick;

  // Under contention the port that was not served last wins.
  assign pick = (req0 && req1) ? ~last_grant : req1;

  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign busy  = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      done_q     <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      opt_l      <= '0;
      a_l        <= '0;
      b_l        <= '0;
      sl         <= '0;
      ct         <= 1'b0;
      z_lo       <= 1'b0;
      res        <= '0;
      res_zero   <= 1'b0;
      res_co     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant_id <= pick;
            opt_l    <= pick ? opt1 : opt0;
            a_l      <= pick ? a1 : a0;
            b_l      <= pick ? b1 : b0;
            state    <= LOW;
          end
        end
        LOW: begin
          sl    <= alu_s;
          ct    <= alu_co;
          z_lo  <= alu_zero;
          state <= HIGH;
        end
        HIGH: begin
          res              <= {alu_s, sl};
          res_zero         <= z_lo & alu_zero;
          res_co           <= alu_co;
          done_q[grant_id] <= 1'b1;
          last_grant       <= grant_id;
          state            <= DONE;
        end
        DONE: begin
          // Requests are deliberately not sampled here so the served port can drop req.
          done_q <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    alu_opt = opt_l;
    alu_a   = '0;
    alu_b   = '0;
    alu_ci  = 1'b0;
    case (state)
      LOW: begin
        alu_a = a_l[7:0];
        alu_b = b_l[7:0];
      end
      HIGH: begin
        alu_a  = a_l[15:8];
        alu_b  = b_l[15:8];
        alu_ci = ct;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Directed and randomized bench for alu_share_sequencer with a bench-side byte ALU
// and a whole-word arithmetic reference for the expected 16-bit results.
module tb_alu_share_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  opt0, opt1;
  logic [15:0] a0, b0, a1, b1;
  logic        done0, done1;
  logic [15:0] res;
  logic        res_zero, res_co, busy, grant_id;
  logic [2:0]  alu_opt;
  logic [7:0]  alu_a, alu_b, alu_s;
  logic        alu_ci, alu_zero, alu_co;

  int total = 0;
  int bad   = 0;

  alu_share_sequencer #(.NPORT(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .opt0(opt0), .a0(a0), .b0(b0),
    .req1(req1), .opt1(opt1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .res(res), .res_zero(res_zero), .res_co(res_co),
    .busy(busy), .grant_id(grant_id),
    .alu_opt(alu_opt), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_co(alu_co)
  );

  always #5 clk = ~clk;

  // Byte ALU: 0 = add with carry-in, 1 = xor, 2 = and, anything else = add.
  always_comb begin
    alu_co = 1'b0;
    case (alu_opt)
      3'd1:    alu_s = alu_a ^ alu_b;
      3'd2:    alu_s = alu_a & alu_b;
      default: {alu_co, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
    endcase
    alu_zero = (alu_s == 8'd0);
  end

  // Whole-word reference: {zero, carry, result}.
  function automatic logic [17:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      3'd1:    r = a ^ b;
      3'd2:    r = a & b;
      default: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[15:0];
        c   = sum[16];
      end
    endcase
    return {(r == 16'd0), c, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rq, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b);
    if (p == 0) begin
      req0 = rq; opt0 = op; a0 = a; b0 = b;
    end else begin
      req1 = rq; opt1 = op; a1 = a; b1 = b;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // Waits (bounded) for port p's done; counts edges taken and any foreign done pulses.
  task automatic wait_done(input int p, output int cyc);
    bit seen;
    int other;
    seen  = 1'b0;
    other = 0;
    cyc   = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      cyc++;
      if ((p == 0) ? done0 : done1) seen = 1'b1;
      if ((p == 0) ? done1 : done0) other++;
    end
    check($sformatf("done%0d_seen", p), seen, 1);
    check($sformatf("no_foreign_done_p%0d", p), other, 0);
  endtask

  task automatic check_result(input string tag, input int p, input logic [2:0] op,
                              input logic [15:0] a, input logic [15:0] b);
    logic [17:0] exp;
    exp = model(op, a, b);
    check({tag, "_res"}, res, exp[15:0]);
    check({tag, "_co"}, res_co, exp[16]);
    check({tag, "_zero"}, res_zero, exp[17]);
    check({tag, "_grant"}, grant_id, p[0]);
  endtask

  // One uncontended operation from IDLE: request, result, single-cycle done.
  task automatic single_op(input string tag, input int p, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b);
    int cyc;
    set_port(p, 1'b1, op, a, b);
    wait_done(p, cyc);
    check({tag, "_latency"}, cyc, 3);
    check_result(tag, p, op, a, b);
    drop_req(p);
    tick();
    check({tag, "_done_width"}, {done1, done0}, 2'b00);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int          cyc;
    int          exp_p;
    logic [2:0]  pop [2];
    logic [15:0] pa  [2];
    logic [15:0] pb  [2];
    logic [15:0] sb;

    reset = 1'b0;
    set_port(0, 1'b0, 3'd0, 16'd0, 16'd0);
    set_port(1, 1'b0, 3'd0, 16'd0, 16'd0);
    #2;
    check("rst_outputs", {done1, done0, busy, grant_id, res_zero, res_co}, 6'd0);
    check("rst_res", res, 16'd0);
    tick();
    reset = 1'b1;
    tick();

    single_op("add_single", 0, 3'd0, 16'h00FF, 16'h0001);
    single_op("carry_zero", 1, 3'd0, 16'hFFFF, 16'h0001);

    // Contention straight out of reset: port 0 first, port 1 four cycles later.
    reset = 1'b0;
    #2;
    pa[0] = 16'($urandom); pb[0] = 16'($urandom); pop[0] = 3'd0;
    pa[1] = 16'($urandom); pb[1] = 16'($urandom); pop[1] = 3'd0;
    set_port(0, 1'b1, pop[0], pa[0], pb[0]);
    set_port(1, 1'b1, pop[1], pa[1], pb[1]);
    tick();
    reset = 1'b1;
    wait_done(0, cyc);
    check("cont_first_latency", cyc, 3);
    check_result("cont_p0", 0, pop[0], pa[0], pb[0]);
    drop_req(0);
    wait_done(1, cyc);
    check("cont_gap", cyc, 4);
    check_result("cont_p1", 1, pop[1], pa[1], pb[1]);
    drop_req(1);
    tick();

    // Back-to-back fairness: both keep requesting, new operands after each done.
    for (int p = 0; p < 2; p++) begin
      pop[p] = 3'($urandom_range(0, 3));
      pa[p]  = 16'($urandom);
      pb[p]  = 16'($urandom);
      set_port(p, 1'b1, pop[p], pa[p], pb[p]);
    end
    exp_p = 0;
    for (int k = 0; k < 6; k++) begin
      wait_done(exp_p, cyc);
      check($sformatf("fair%0d_latency", k), cyc, 3);
      check($sformatf("fair%0d_busy_done", k), busy, 1);
      check_result($sformatf("fair%0d", k), exp_p, pop[exp_p], pa[exp_p], pb[exp_p]);
      pop[exp_p] = 3'($urandom_range(0, 3));
      pa[exp_p]  = 16'($urandom);
      pb[exp_p]  = 16'($urandom);
      set_port(exp_p, 1'b1, pop[exp_p], pa[exp_p], pb[exp_p]);
      tick();
      check($sformatf("fair%0d_idle_gap", k), busy, 0);
      exp_p = 1 - exp_p;
    end
    drop_req(0);
    drop_req(1);
    tick();
    tick();

    // Operand stability: everything changes right after the grant edge.
    sb = 16'($urandom);
    set_port(0, 1'b1, 3'd0, 16'h1234, sb);
    tick();
    set_port(0, 1'b0, 3'd1, 16'h0000, ~sb);
    wait_done(0, cyc);
    check("stable_latency", cyc, 2);
    check_result("stable", 0, 3'd0, 16'h1234, sb);
    tick();

    // Randomized single operations on either port.
    for (int k = 0; k < 16; k++) begin
      single_op($sformatf("rnd%0d", k), int'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom));
    end

    // Reset while in HIGH: everything clears at once, pending req1 is then served.
    single_op("pre_reset", 0, 3'd0, 16'h1111, 16'h2222);
    set_port(0, 1'b1, 3'd0, 16'hFFFF, 16'hFFFF);
    tick();
    tick();
    check("mid_busy_high", busy, 1);
    pa[1] = 16'($urandom); pb[1] = 16'($urandom);
    set_port(1, 1'b1, 3'd0, pa[1], pb[1]);
    drop_req(0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ctrl", {done1, done0, busy, grant_id}, 4'd0);
    check("mid_rst_res", res, 16'd0);
    check("mid_rst_flags", {res_zero, res_co}, 2'd0);
    tick();
    check("mid_rst_hold", {done1, done0, busy}, 3'd0);
    reset = 1'b1;
    wait_done(1, cyc);
    check("post_rst_latency", cyc, 3);
    check_result("post_rst", 1, 3'd0, pa[1], pb[1]);
    drop_req(1);
    tick();
    check("post_rst_idle", {done1, done0, busy}, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
